// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit out per shift_en cycle.
// First bit appears the cycle after acceptance; back-to-back words stream with no idle gap.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             out_nxt, out_valid_nxt, frame_start_nxt;
  logic             last, accept;

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      out         <= IDLE_BIT;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      sr          <= sr_nxt;
      cnt         <= cnt_nxt;
      out         <= out_nxt;
      out_valid   <= out_valid_nxt;
      frame_start <= frame_start_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (shift_en && last && !in_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready        = (state == IDLE) || (state == SHIFT && last && shift_en);
    busy            = (state == SHIFT);
    sr_nxt          = sr;
    cnt_nxt         = cnt;
    out_nxt         = out;
    out_valid_nxt   = out_valid;
    frame_start_nxt = frame_start;
    if (accept) begin
      sr_nxt          = in_data;
      out_nxt         = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
      out_valid_nxt   = 1'b1;
      frame_start_nxt = 1'b1;
      cnt_nxt         = '0;
    end else if (state == SHIFT && shift_en) begin
      if (!last) begin
        // sr is shifted so the next bit always sits one position behind the send end
        sr_nxt          = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        out_nxt         = MSB_FIRST ? sr[WIDTH-2] : sr[1];
        cnt_nxt         = cnt + 1'b1;
        frame_start_nxt = 1'b0;
      end else begin
        out_nxt         = IDLE_BIT;
        out_valid_nxt   = 1'b0;
        frame_start_nxt = 1'b0;
        cnt_nxt         = '0;
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first and LSB-first instances, hand-computed bit streams.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       areset_n;
  logic [7:0] in_data, in_data_l;
  logic       in_valid, in_valid_l, shift_en, shift_en_l;
  logic       in_ready, out, out_valid, frame_start, busy;
  logic       in_ready_l, out_l, out_valid_l, frame_start_l, busy_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .areset_n(areset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .shift_en(shift_en), .out(out), .out_valid(out_valid),
    .frame_start(frame_start), .busy(busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .areset_n(areset_n), .in_data(in_data_l), .in_valid(in_valid_l),
    .in_ready(in_ready_l), .shift_en(shift_en_l), .out(out_l), .out_valid(out_valid_l),
    .frame_start(frame_start_l), .busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] bb;
    logic [2:0]  win;
    int          hits;
    int          idx;

    areset_n = 1'b0; in_data = '0; in_valid = 1'b0; shift_en = 1'b1;
    in_data_l = '0; in_valid_l = 1'b0; shift_en_l = 1'b1;
    #1;
    check("rst_out", 32'(out), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    areset_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);

    // single word A0, MSB first, with a downstream 101 detector model
    @(negedge clk);
    w = 8'hA0; in_data = w; in_valid = 1'b1;
    #1 check("a0_ready_idle", 32'(in_ready), 1);
    win = '0; hits = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin in_valid = 1'b0; in_data = 8'h5A; end
      #1;
      check($sformatf("a0_out[%0d]", k), 32'(out), 32'(w[7-k]));
      check($sformatf("a0_vld[%0d]", k), 32'(out_valid), 1);
      check($sformatf("a0_fs[%0d]", k), 32'(frame_start), (k == 0) ? 1 : 0);
      win = {win[1:0], out};
      if (k >= 2 && win == 3'b101) hits++;
    end
    check("a0_det101", 32'(hits), 1);
    @(negedge clk); #1;
    check("a0_end_vld", 32'(out_valid), 0);
    check("a0_end_out", 32'(out), 0);
    check("a0_end_busy", 32'(busy), 0);
    check("a0_end_ready", 32'(in_ready), 1);

    // back-to-back A5 then 3C with in_valid held
    @(negedge clk);
    bb = 16'hA53C; in_data = 8'hA5; in_valid = 1'b1;
    #1 check("bb_ready_idle", 32'(in_ready), 1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) in_data = 8'h3C;
      if (k == 8) in_valid = 1'b0;
      #1;
      check($sformatf("bb_out[%0d]", k), 32'(out), 32'(bb[15-k]));
      check($sformatf("bb_vld[%0d]", k), 32'(out_valid), 1);
      check($sformatf("bb_fs[%0d]", k), 32'(frame_start), (k == 0 || k == 8) ? 1 : 0);
      if (k < 15) check($sformatf("bb_ready[%0d]", k), 32'(in_ready), (k == 7) ? 1 : 0);
    end
    @(negedge clk); #1;
    check("bb_end_vld", 32'(out_valid), 0);

    // stall: shift_en low for 3 cycles while bit index 3 is presented
    @(negedge clk);
    w = 8'hF0; in_data = w; in_valid = 1'b1;
    for (int t = 0; t < 11; t++) begin
      @(negedge clk);
      if (t == 0) in_valid = 1'b0;
      shift_en = (t >= 3 && t <= 5) ? 1'b0 : 1'b1;
      #1;
      idx = (t <= 3) ? t : ((t <= 6) ? 3 : t - 3);
      check($sformatf("st_out[%0d]", t), 32'(out), 32'(w[7-idx]));
      check($sformatf("st_vld[%0d]", t), 32'(out_valid), 1);
      check($sformatf("st_fs[%0d]", t), 32'(frame_start), (t == 0) ? 1 : 0);
      if (t < 10) check($sformatf("st_ready[%0d]", t), 32'(in_ready), 0);
    end
    @(negedge clk); shift_en = 1'b1; #1;
    check("st_end_vld", 32'(out_valid), 0);

    // LSB-first instance
    @(negedge clk);
    w = 8'h01; in_data_l = w; in_valid_l = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) in_valid_l = 1'b0;
      #1;
      check($sformatf("lsb_out[%0d]", k), 32'(out_l), 32'(w[k]));
      check($sformatf("lsb_fs[%0d]", k), 32'(frame_start_l), (k == 0) ? 1 : 0);
    end
    @(negedge clk); #1;
    check("lsb_end_vld", 32'(out_valid_l), 0);

    // reset mid-word, then 00 must come out clean
    @(negedge clk);
    in_data = 8'hFF; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
      #1 check($sformatf("mr_ff[%0d]", k), 32'(out), 1);
    end
    @(posedge clk); #3;
    areset_n = 1'b0;
    #1;
    check("mr_out", 32'(out), 0);
    check("mr_vld", 32'(out_valid), 0);
    check("mr_fs", 32'(frame_start), 0);
    check("mr_busy", 32'(busy), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check($sformatf("mr_hold_out[%0d]", k), 32'(out), 0);
    end
    @(negedge clk);
    areset_n = 1'b1;
    #1 check("mr_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_data = 8'h00; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
      #1;
      check($sformatf("mr_00_out[%0d]", k), 32'(out), 0);
      check($sformatf("mr_00_vld[%0d]", k), 32'(out_valid), 1);
      check($sformatf("mr_00_fs[%0d]", k), 32'(frame_start), (k == 0) ? 1 : 0);
    end
    @(negedge clk); #1;
    check("mr_end_vld", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial pattern-detector FSMs. It accepts `WIDTH`-bit words over a valid/ready handshake and emits them one bit per enabled cycle on a registered serial output, which drives the detector's 1-bit `in`. Back-to-back words stream with no idle gap. When the serializer is idle, the line holds a fixed idle level.

## Interface
- `WIDTH`, 8: word width in bits, ≥2.
- `MSB_FIRST`, 1: 1 = bit `WIDTH-1` sent first; 0 = bit 0 sent first.
- `IDLE_BIT`, 0: level driven on `out` when no word is in flight.

- `clk`  in  1  sole clock, rising edge.
- `areset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  word to serialize.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  combinational; a word is accepted on an edge where `in_valid && in_ready`.
- `shift_en`  in  1  bit-rate enable; a bit is consumed downstream on cycles with `out_valid && shift_en`.
- `out`  out  1  registered serial bit (to detector `in`).
- `out_valid`  out  1  registered; `out` carries word data.
- `frame_start`  out  1  registered; high while `out` carries the first bit of a word.
- `busy`  out  1  state == SHIFT.

## Operation
- States: IDLE, SHIFT. Internal `WIDTH`-bit shift register `sr`, bit counter `cnt` (width clog2(WIDTH)).
- Reset (async, `areset_n`=0) sets:
  - state IDLE, `cnt`=0, `sr`=0
  - `out`=IDLE_BIT, `out_valid`=0, `frame_start`=0
  - reset takes precedence over any transfer.
- `in_ready` = (state==IDLE) || (state==SHIFT && `cnt`==WIDTH-1 && `shift_en`). Handshakes while `areset_n`=0 are ignored.
- Load action, on accepted transfer:
  - `sr`←`in_data`
  - `out`←first bit per `MSB_FIRST`
  - `out_valid`←1, `frame_start`←1, `cnt`←0, state←SHIFT.
- IDLE: load on accept; otherwise hold, with `out`=IDLE_BIT and `out_valid`=0. `shift_en` is don't-care in IDLE.
- SHIFT, `shift_en`=0: all registers hold. The current bit stays on `out`, and `frame_start` holds its value.
- SHIFT, `shift_en`=1, `cnt`<WIDTH-1:
  - `out`←next bit in order
  - `cnt`←`cnt`+1, `frame_start`←0.
- SHIFT, `shift_en`=1, `cnt`==WIDTH-1 (last bit being consumed):
  - `in_valid`=1: load action (seamless, no gap).
  - `in_valid`=0: state←IDLE, `out`←IDLE_BIT, `out_valid`←0, `frame_start`←0, `cnt`←0.
- `in_data` is sampled only at acceptance. Later changes have no effect on the word in flight.
- Reset mid-word: the word is dropped, with no partial output after reset. The next accepted word starts at its first bit.

## Timing
- Latency: accept at edge N → first bit on `out` after edge N (valid in cycle N+1).
- With `shift_en` tied 1:
  - a word occupies exactly WIDTH consecutive cycles
  - continuous `in_valid` gives 100% line utilization; `in_ready` pulses once per WIDTH cycles.
- With `shift_en` duty-cycled: each bit is held until a cycle with `shift_en`=1 consumes it.
- `frame_start` is high exactly for the cycles the first bit is presented.
- All outputs except `in_ready` are registered with no combinational path from inputs. `in_ready` depends on state, `cnt` and `shift_en` only, never on `in_valid`.

## Test plan
- Reset values: assert `areset_n`=0 for 3 cycles mid-simulation, asynchronous to `clk` → `out`=IDLE_BIT, `out_valid`=0, `frame_start`=0, `busy`=0 immediately; `in_ready`=1 after release.
- Single word: WIDTH=8, MSB_FIRST=1, `shift_en`=1, send 8'hA0 → `out` = 1,0,1,0,0,0,0,0 on cycles N+1..N+8; `frame_start` only on N+1; `out_valid`=0 and `out`=0 from N+9. A downstream 101 detector flags once.
- Back-to-back: send 8'hA5 then 8'h3C with `in_valid` held → 16 contiguous valid bits 10100101 00111100; `frame_start` on bits 1 and 9; `in_ready` high only in the IDLE cycle and on cycle N+8.
- Stall: send 8'hF0 with `shift_en` low for 3 cycles while bit index 3 is presented → `out`=1 held 4 cycles, remaining bits unchanged, no `in_ready` during stall.
- LSB_FIRST: MSB_FIRST=0, send 8'h01 → `out` = 1,0,0,0,0,0,0,0.
- Reset mid-word: send 8'hFF, assert reset after bit 4, release, send 8'h00 → no 1s after reset; 8 zeros with `frame_start` on the first.
